// File: rtl/vga_sec_ram_arbiter_if.sv
// rtl/vga_sec_ram_arbiter_if.sv - VGA/CPU/RAM bus bundle for the VGA seconds RAM arbiter
//
// Signals:
//   vga_req, vga_addr         VGA scan read request (single cycle) and address
//   vga_valid, vga_data       registered VGA read response, one cycle after grant
//   cpu_req, cpu_we,
//   cpu_addr, cpu_wdata       CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata        one-cycle CPU completion pulse and read data
//   ram_addr, ram_d, ram_we   drive the single RAM port
//   ram_q                     combinational RAM read data
//
// Modports:
//   slave   the arbiter side
//   master  the requesters plus the RAM instance
interface vga_sec_ram_arbiter_if #(
    parameter int ADDR_W = 4
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_valid;
    logic              vga_data;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_d;
    logic              ram_we;
    logic              ram_q;

    modport slave (
        input  vga_req, vga_addr,
        output vga_valid, vga_data,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output ram_addr, ram_d, ram_we,
        input  ram_q
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_valid, vga_data,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  ram_addr, ram_d, ram_we,
        output ram_q
    );
endinterface

// File: rtl/vga_sec_ram_arbiter.sv
// rtl/vga_sec_ram_arbiter.sv - single-port VGA seconds RAM arbiter with clear sequencer
//
// Ports:
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   clr_start  pulse, starts a full RAM clear (ignored while clearing)
//   clr_busy   high for the 2^ADDR_W clear-write cycles
//   clr_done   one-cycle pulse after the last clear write
//   bus        VGA / CPU requesters and RAM port (slave modport)
module vga_sec_ram_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    vga_sec_ram_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam int                SW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     STARVE_MX = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [SW-1:0]     starve;

    logic idle_active;
    logic cpu_elig;
    logic force_cpu;
    logic vga_gnt;
    logic cpu_gnt;

    // Grants are also gated by rst_n so the RAM port goes quiet the moment
    // reset asserts, even while requests are still being presented.
    always_comb begin
        idle_active = rst_n && (state == ST_IDLE);
        // cpu_ack is registered, so a CPU request is ignored during its own
        // ack cycle; this keeps a held request from being served twice.
        cpu_elig    = bus.cpu_req && !bus.cpu_ack;
        force_cpu   = cpu_elig && (starve == STARVE_MX);
        vga_gnt     = idle_active && bus.vga_req && !force_cpu;
        cpu_gnt     = idle_active && cpu_elig && !vga_gnt;
    end

    always_comb begin
        bus.ram_addr = '0;
        bus.ram_d    = 1'b0;
        bus.ram_we   = 1'b0;
        if (rst_n && (state == ST_CLEAR)) begin
            bus.ram_addr = clr_cnt;
            bus.ram_we   = 1'b1;
        end else if (vga_gnt) begin
            bus.ram_addr = bus.vga_addr;
        end else if (cpu_gnt) begin
            bus.ram_addr = bus.cpu_addr;
            bus.ram_we   = bus.cpu_we;
            bus.ram_d    = bus.cpu_wdata;
        end
    end

    assign clr_busy = (state == ST_CLEAR);

    // Read responses: the RAM is combinational, so ram_q already reflects
    // the granted address in the grant cycle and is captured at its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vga_valid <= 1'b0;
            bus.vga_data  <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= 1'b0;
        end else begin
            bus.vga_valid <= vga_gnt;
            if (vga_gnt) begin
                bus.vga_data <= bus.ram_q;
            end
            bus.cpu_ack   <= cpu_gnt;
            bus.cpu_rdata <= cpu_gnt && !bus.cpu_we && bus.ram_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            starve   <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                    // Only a VGA win over an eligible CPU counts; every other
                    // idle outcome means the CPU was served or is not waiting.
                    if (vga_gnt && cpu_elig) begin
                        if (starve != STARVE_MX) begin
                            starve <= starve + SW'(1);
                        end
                    end else begin
                        starve <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state    <= ST_IDLE;
                        clr_cnt  <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

endmodule
